// File: rtl/mac_pkg.sv
// Shared definitions for accumulating MAC back-end stages.
package mac_pkg;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned CNT_W_DEF  = 8;

  // Widest accumulator any stage may clamp to through sat_clamp.
  localparam int unsigned SAT_MAX_W  = 64;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Clamp a one-bit-wider signed sum into the signed acc_w range.
  // The sum arrives sign-extended to SAT_MAX_W+1 bits so callers of any
  // width share one implementation; callers truncate the result to acc_w.
  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input  logic signed [SAT_MAX_W:0] sum,
    input  int unsigned               acc_w,
    output logic                      clip
  );
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    one  = {{SAT_MAX_W{1'b0}}, 1'b1};
    hi   = (one <<< (acc_w - 1)) - one;
    lo   = -(one <<< (acc_w - 1));
    clip = 1'b0;
    sat_clamp = SAT_MAX_W'(sum);
    if (sum > hi) begin
      clip      = 1'b1;
      sat_clamp = SAT_MAX_W'(hi);
    end else if (sum < lo) begin
      clip      = 1'b1;
      sat_clamp = SAT_MAX_W'(lo);
    end
  endfunction

endpackage

// File: rtl/sat_add_s.sv
// Combinational sign-extending saturating adder: sum = clamp(sext(a) + b).
module sat_add_s
  import mac_pkg::*;
#(
  parameter int unsigned A_W = PROD_W_DEF,
  parameter int unsigned S_W = ACC_W_DEF
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [S_W-1:0] b,
  output logic signed [S_W-1:0] sum,
  output logic                  clip
);

  logic signed [S_W:0] raw;

  // Add at one extra bit so overflow is visible, then clamp back to S_W.
  always_comb begin
    raw  = (S_W+1)'(a) + (S_W+1)'(b);
    clip = 1'b0;
    sum  = S_W'(sat_clamp((SAT_MAX_W+1)'(raw), S_W, clip));
  end

endmodule

// File: rtl/mul8s_acc_stage.sv
// Saturating group accumulator for signed product streams, with a
// one-entry valid/ready output register.
module mul8s_acc_stage
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_sat
);

  buf_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] sum;
  logic                    clip;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    accept;
  logic                    accept_last;

  sat_add_s #(
    .A_W(PROD_W),
    .S_W(ACC_W)
  ) u_add (
    .a   (in_prod),
    .b   (acc_q),
    .sum (sum),
    .clip(clip)
  );

  // Handshake outputs derive from buffer state and out_ready only.
  always_comb begin
    out_valid   = (state_q == BUF_FULL);
    in_ready    = (state_q == BUF_EMPTY) || out_ready;
    accept      = in_valid && in_ready;
    accept_last = accept && in_last;
    out_acc     = out_acc_q;
    out_count   = out_count_q;
    out_sat     = out_sat_q;
  end

  // Buffer refills in the same cycle it drains, so back-to-back groups see no bubble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUF_EMPTY: if (accept_last) state_d = BUF_FULL;
      BUF_FULL: begin
        if (accept_last)    state_d = BUF_FULL;
        else if (out_ready) state_d = BUF_EMPTY;
      end
      default:              state_d = BUF_EMPTY;
    endcase
  end

  // Accumulate non-last beats; a last beat publishes the group and clears.
  always_comb begin
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (accept) begin
      if (in_last) begin
        out_acc_d   = sum;
        out_count_d = cnt_inc;
        out_sat_d   = sat_q | clip;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
        sat_d = sat_q | clip;
      end
    end
  end

  // State and data registers; reset discards any partial group.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= BUF_EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_mul8s_acc_stage.sv
// Scoreboard bench: two configurations (24/8 and 16/4) share one stimulus stream.
module tb_mul8s_acc_stage;

  logic clock = 1'b0;
  logic reset;
  logic in_valid, in_last, out_ready;
  logic signed [15:0] in_prod;

  logic in_ready0, out_valid0, out_sat0;
  logic signed [23:0] out_acc0;
  logic [7:0] out_count0;
  logic in_ready1, out_valid1, out_sat1;
  logic signed [15:0] out_acc1;
  logic [3:0] out_count1;

  always #5 clock = ~clock;

  mul8s_acc_stage #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_acc(out_acc0), .out_count(out_count0), .out_sat(out_sat0));

  mul8s_acc_stage #(.PROD_W(16), .ACC_W(16), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_acc(out_acc1), .out_count(out_count1), .out_sat(out_sat1));

  typedef struct {
    longint acc;
    longint count;
    longint sat;
  } res_t;

  res_t q0[$];
  res_t q1[$];

  localparam int ACCW [2] = '{24, 16};
  localparam int CMAX [2] = '{255, 15};

  longint m_acc [2];
  longint m_cnt [2];
  bit     m_sat [2];

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
      m_sat[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endfunction

  // Reference: plain integer sum clamped to the accumulator range.
  function automatic void model_accept(input longint prod, input bit last);
    for (int i = 0; i < 2; i++) begin
      longint hi, lo, s, n;
      bit c;
      res_t r;
      hi = (64'sd1 <<< (ACCW[i] - 1)) - 1;
      lo = -hi - 1;
      s  = m_acc[i] + prod;
      c  = 1'b0;
      if (s > hi) begin s = hi; c = 1'b1; end
      else if (s < lo) begin s = lo; c = 1'b1; end
      n = (m_cnt[i] + 1 > CMAX[i]) ? CMAX[i] : m_cnt[i] + 1;
      if (last) begin
        r.acc = s; r.count = n; r.sat = longint'(m_sat[i] | c);
        if (i == 0) q0.push_back(r); else q1.push_back(r);
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
      end else begin
        m_acc[i] = s; m_cnt[i] = n; m_sat[i] = m_sat[i] | c;
      end
    end
  endfunction

  // Monitor: checks handshake rule, output stability under stall, and pops on transfer.
  bit     held  [2];
  longint h_acc [2];
  longint h_cnt [2];
  longint h_sat [2];
  longint a_acc [2];
  longint a_cnt [2];
  longint a_sat [2];
  bit     a_v   [2];
  bit     a_r   [2];
  res_t   e;

  always @(negedge clock) begin
    a_acc[0] = out_acc0;  a_acc[1] = out_acc1;
    a_cnt[0] = out_count0; a_cnt[1] = out_count1;
    a_sat[0] = out_sat0;  a_sat[1] = out_sat1;
    a_v[0] = out_valid0;  a_v[1] = out_valid1;
    a_r[0] = in_ready0;   a_r[1] = in_ready1;
    if (reset) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("in_ready_rule%0d", i), a_r[i], longint'(!a_v[i] || out_ready));
        if (a_v[i]) begin
          if (held[i]) begin
            check($sformatf("stall_acc%0d", i), a_acc[i], h_acc[i]);
            check($sformatf("stall_cnt%0d", i), a_cnt[i], h_cnt[i]);
            check($sformatf("stall_sat%0d", i), a_sat[i], h_sat[i]);
          end
          if (out_ready) begin
            held[i] = 1'b0;
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              check($sformatf("unexpected_result%0d", i), 1, 0);
            end else begin
              if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
              check($sformatf("out_acc%0d", i), a_acc[i], e.acc);
              check($sformatf("out_count%0d", i), a_cnt[i], e.count);
              check($sformatf("out_sat%0d", i), a_sat[i], e.sat);
            end
          end else begin
            held[i]  = 1'b1;
            h_acc[i] = a_acc[i];
            h_cnt[i] = a_cnt[i];
            h_sat[i] = a_sat[i];
          end
        end else begin
          held[i] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input longint prod, input bit last);
    bit ok, acc;
    ok = 1'b0;
    in_valid = 1'b1;
    in_prod  = 16'(prod);
    in_last  = last;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      acc = in_ready0;
      step();
      if (acc) begin
        model_accept(prod, last);
        ok = 1'b1;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int n = 0; n < 200 && (q0.size() + q1.size()) != 0; n++) step();
    check("drain_pending", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] p;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
    model_reset();
    step(); step();
    check("rst_valid0", out_valid0, 0);
    check("rst_valid1", out_valid1, 0);
    check("rst_acc0", out_acc0, 0);
    check("rst_count0", out_count0, 0);
    check("rst_sat0", out_sat0, 0);
    reset = 1'b0;
    step();

    // Basic group plus one-cycle latency.
    send(100, 0); send(-30, 0); send(50, 1);
    check("latency_valid0", out_valid0, 1);
    check("latency_valid1", out_valid1, 1);
    drain();

    // Single-beat group.
    send(-16256, 1);
    drain();

    // Saturation (only the 16-bit accumulator clamps).
    send(16384, 0); send(16384, 0); send(-100, 1);
    drain();

    // Backpressure then no-bubble refill.
    out_ready = 1'b0;
    send(9, 1);
    in_valid = 1'b1; in_prod = 16'sd7; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("bp_in_ready0", in_ready0, 0);
      check("bp_in_ready1", in_ready1, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", in_ready0, 1);
    step();
    model_accept(7, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check("no_bubble0", out_valid0, 1);
    check("no_bubble1", out_valid1, 1);
    drain();

    // Count saturation on the 4-bit counter.
    for (int k = 0; k < 20; k++) send(1, k == 19);
    drain();

    // Reset mid-group discards the partial sum.
    send(500, 0); send(500, 0);
    reset = 1'b1;
    step();
    model_reset();
    check("midrst_valid0", out_valid0, 0);
    reset = 1'b0;
    step();
    check("postrst_valid0", out_valid0, 0);
    send(3, 1);
    drain();

    // Randomized groups with random backpressure and frequent extremes.
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 7))
        0:       p = 16'sh7FFF;
        1:       p = 16'sh8000;
        default: p = 16'($urandom);
      endcase
      send(p, $urandom_range(0, 4) == 0);
    end
    send(1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
